// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM slave-port arbiter.
package avalon_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

endpackage

// File: rtl/avalon_s_rr_picker.sv
// Combinational NH-way picker: first requester at or after i_start, wrapping modulo NH.
module avalon_s_rr_picker #(
  parameter int unsigned NH = 3,
  parameter int unsigned IW = $clog2(NH)
) (
  input  logic [NH-1:0] i_req,
  input  logic [IW-1:0] i_start,
  output logic [IW-1:0] o_winner,
  output logic          o_valid
);

  logic [NH-1:0] w_rot;
  int unsigned   w_pos;
  int unsigned   w_sum;

  // Rotate so that bit 0 of w_rot corresponds to host i_start.
  assign w_rot   = NH'({i_req, i_req} >> i_start);
  assign o_valid = |i_req;

  always_comb begin
    w_pos = 0;
    for (int k = NH - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = k;
    end
    w_sum = int'(i_start) + w_pos;
    if (w_sum >= NH) w_sum = w_sum - NH;
    o_winner = IW'(w_sum);
  end

endmodule

// File: rtl/avalon_s_arbiter.sv
// Shares one Avalon-MM simple-slave device among NH hosts, one transfer per grant.
// Define AVALON_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module avalon_s_arbiter
  import avalon_pkg::*;
#(
  parameter int unsigned NH = 3,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NH-1:0]              hosts_avn_read,
  input  logic [NH-1:0]              hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]      hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]    hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]      hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]      hosts_avn_readdata,
  output logic [NH-1:0]              hosts_avn_waitrequest,
  output logic                       device_avn_read,
  output logic                       device_avn_write,
  output logic [AW-1:0]              device_avn_address,
  output logic [DW/8-1:0]            device_avn_byte_enable,
  output logic [DW-1:0]              device_avn_writedata,
  input  logic [DW-1:0]              device_avn_readdata,
  input  logic                       device_avn_waitrequest
);

  localparam int unsigned IW = $clog2(NH);

  arb_state_e    r_state;
  logic [IW-1:0] r_grant;
  logic [NH-1:0] w_req;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_winner;
  logic          w_valid;
  logic          w_busy;

  assign w_req  = hosts_avn_read | hosts_avn_write;
  assign w_busy = (r_state == ARB_BUSY);

`ifdef AVALON_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_last_grant;

  assign w_start = (r_last_grant == IW'(NH - 1)) ? '0 : r_last_grant + IW'(1);
`else
  assign w_start = '0;
`endif

  avalon_s_rr_picker #(
    .NH (NH),
    .IW (IW)
  ) u_picker (
    .i_req    (w_req),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
      r_last_grant <= IW'(NH - 1);
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_grant      <= w_winner;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_winner;
`endif
            r_state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Either the transfer completed or the grantee abandoned its request.
          if (!w_req[r_grant] || !device_avn_waitrequest) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    device_avn_read        = w_busy & hosts_avn_read[r_grant];
    device_avn_write       = w_busy & hosts_avn_write[r_grant];
    device_avn_address     = hosts_avn_address[r_grant];
    device_avn_byte_enable = hosts_avn_byte_enable[r_grant];
    device_avn_writedata   = hosts_avn_writedata[r_grant];
    hosts_avn_waitrequest  = '1;
    if (w_busy) hosts_avn_waitrequest[r_grant] = device_avn_waitrequest;
  end

  assign hosts_avn_readdata = {NH{device_avn_readdata}};

endmodule

// File: tb/tb_avalon_s_arbiter.sv
// Scoreboard bench for avalon_s_arbiter: directed scenarios plus randomized host traffic.
module tb_avalon_s_arbiter;

  localparam int NH = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int NCYC = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NH-1:0]         h_rd;
  logic [NH-1:0]         h_wr;
  logic [NH-1:0][AW-1:0] h_addr;
  logic [NH-1:0][BW-1:0] h_be;
  logic [NH-1:0][DW-1:0] h_wd;
  logic [NH-1:0][DW-1:0] h_rdata;
  logic [NH-1:0]         h_wait;
  logic                  d_rd;
  logic                  d_wr;
  logic [AW-1:0]         d_addr;
  logic [BW-1:0]         d_be;
  logic [DW-1:0]         d_wd;
  logic [DW-1:0]         d_rdata;
  logic                  d_wait;

  avalon_s_arbiter #(
    .NH (NH),
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .hosts_avn_read         (h_rd),
    .hosts_avn_write        (h_wr),
    .hosts_avn_address      (h_addr),
    .hosts_avn_byte_enable  (h_be),
    .hosts_avn_writedata    (h_wd),
    .hosts_avn_readdata     (h_rdata),
    .hosts_avn_waitrequest  (h_wait),
    .device_avn_read        (d_rd),
    .device_avn_write       (d_wr),
    .device_avn_address     (d_addr),
    .device_avn_byte_enable (d_be),
    .device_avn_writedata   (d_wd),
    .device_avn_readdata    (d_rdata),
    .device_avn_waitrequest (d_wait)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  // Reference model: one transfer per grant, winner chosen from the request set in an idle cycle.
  typedef struct {
    logic [1:0]    host;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_busy = 1'b0;
  logic [1:0] m_g    = 2'd0;
  int         m_last = NH - 1;

  function automatic int pick(input logic [NH-1:0] req, input int last);
    int idx;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NH; k++) begin
      idx = (last + k) % NH;
      if (req[idx[1:0]]) return idx;
    end
`else
    for (int k = 0; k < NH; k++) begin
      idx = k;
      if (req[idx[1:0]]) return idx;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_last <= NH - 1;
      exp_q.delete();
    end else if (m_busy) begin
      if (!(h_rd[m_g] | h_wr[m_g]) || !d_wait) m_busy <= 1'b0;
    end else if (|(h_rd | h_wr)) begin
      int   w;
      exp_t e;
      w      = pick(h_rd | h_wr, m_last);
      e.host = w[1:0];
      e.rd   = h_rd[w[1:0]];
      e.wr   = h_wr[w[1:0]];
      e.addr = h_addr[w[1:0]];
      e.be   = h_be[w[1:0]];
      e.wd   = h_wd[w[1:0]];
      exp_q.push_back(e);
      m_g    <= w[1:0];
      m_last <= w;
      m_busy <= 1'b1;
    end
  end

  // Monitor: mid-cycle checks of forwarding/stalls, and scoreboard pop on each completed transfer.
  int done_cnt[NH];
  int n_done = 0;
  int seen_q[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("dev_read", d_rd, m_busy & h_rd[m_g]);
      chk("dev_write", d_wr, m_busy & h_wr[m_g]);
      for (int h = 0; h < NH; h++) begin
        chk($sformatf("host%0d_wait", h), h_wait[h],
            (m_busy && m_g == h[1:0]) ? d_wait : 1'b1);
      end
      if ((d_rd | d_wr) && !d_wait) begin
        int   g;
        exp_t e;
        g = -1;
        for (int h = NH - 1; h >= 0; h--) if (!h_wait[h]) g = h;
        if (g < 0 || exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL xfer_match: got grantee %0d with %0d queued, expected one of each",
                   g, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          chk("grant_host", g, e.host);
          chk("xfer_rd", d_rd, e.rd);
          chk("xfer_wr", d_wr, e.wr);
          chk("xfer_addr", d_addr, e.addr);
          chk("xfer_be", d_be, e.be);
          chk("xfer_wdata", d_wd, e.wd);
          chk("xfer_rdata", h_rdata[g[1:0]], d_rdata);
          done_cnt[g]++;
          n_done++;
          seen_q.push_back(g);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int seen_cnt[NH];
  bit busy_h[NH];

  initial begin
    int base;
    int exp_order[6];
    int kind;
    bit any;

    h_rd    = '0;
    h_wr    = '0;
    h_addr  = '0;
    h_be    = '0;
    h_wd    = '0;
    d_wait  = 1'b0;
    d_rdata = '0;
    h_addr[0] = 32'h1234_5678;
    h_be[0]   = 4'hA;
    h_wd[0]   = 32'hCAFE_0000;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_dev_read", d_rd, 1'b0);
    chk("rst_dev_write", d_wr, 1'b0);
    chk("rst_waits", h_wait, 3'b111);
    chk("rst_addr_host0", d_addr, 32'h1234_5678);
    chk("rst_be_host0", d_be, 4'hA);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single host read, zero-wait device
    step();
    h_rd[1]   = 1'b1;
    h_addr[1] = 32'h8000_0010;
    h_be[1]   = 4'hF;
    d_rdata   = 32'hDEAD_BEEF;
    mid();
    chk("t1_idle_read", d_rd, 1'b0);
    step();
    mid();
    chk("t1_dev_read", d_rd, 1'b1);
    chk("t1_addr", d_addr, 32'h8000_0010);
    chk("t1_wait1", h_wait[1], 1'b0);
    chk("t1_rdata", h_rdata[1], 32'hDEAD_BEEF);
    step();
    h_rd[1] = 1'b0;

    // Host2 write stalled by the device for four cycles
    step();
    h_wr[2]   = 1'b1;
    h_addr[2] = 32'h4000_0020;
    h_be[2]   = 4'hF;
    h_wd[2]   = 32'h55AA_1234;
    d_wait    = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_dev_write", d_wr, 1'b1);
      chk("t2_addr", d_addr, 32'h4000_0020);
      chk("t2_wdata", d_wd, 32'h55AA_1234);
      chk("t2_wait2", h_wait[2], 1'b1);
      step();
    end
    d_wait = 1'b0;
    mid();
    chk("t2_wait2_release", h_wait[2], 1'b0);
    step();
    h_wr[2] = 1'b0;
    mid();
    chk("t2_idle_write", d_wr, 1'b0);
    chk("t2_idle_waits", h_wait, 3'b111);

    // Three hosts with constant write requests
    step();
    for (int h = 0; h < NH; h++) begin
      h_addr[h] = 32'h1000_0000 + 32'(h * 16);
      h_wd[h]   = 32'hA000_0000 + 32'(h);
      h_be[h]   = 4'hF;
    end
    h_wr   = 3'b111;
    base   = n_done;
    seen_q.delete();
    repeat (12) step();
    h_wr = '0;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 0, 1, 2};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    chk("t3_xfer_count", n_done - base, 6);
    for (int i = 0; i < 6; i++) begin
      if (seen_q.size() > i) chk($sformatf("t3_order%0d", i), seen_q[i], exp_order[i]);
      else chk($sformatf("t3_order%0d", i), -1, exp_order[i]);
    end
    step();

    // Reset while host1 is stalled in BUSY
    h_rd[1]   = 1'b1;
    h_addr[1] = 32'h8000_0040;
    d_wait    = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("t4_rst_read", d_rd, 1'b0);
    chk("t4_rst_waits", h_wait, 3'b111);
    @(posedge clk);
    #1 rst = 1'b1;
    d_wait    = 1'b0;
    h_wr[2]   = 1'b1;
    h_addr[2] = 32'h4000_0080;
    mid();
    chk("t4_idle_read", d_rd, 1'b0);
    step();
    mid();
    chk("t4_regrant_read", d_rd, 1'b1);
    chk("t4_regrant_addr", d_addr, 32'h8000_0040);
    chk("t4_wait1", h_wait[1], 1'b0);
    chk("t4_wait2", h_wait[2], 1'b1);
    step();
    h_rd[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (!h_wait[2]) break;
    end
    chk("t4_host2_served", h_wait[2], 1'b0);
    step();
    h_wr[2] = 1'b0;

    // Randomized traffic, then drain
    for (int h = 0; h < NH; h++) begin
      seen_cnt[h] = done_cnt[h];
      busy_h[h]   = 1'b0;
    end
    for (int cyc = 0; cyc < NCYC + 300; cyc++) begin
      step();
      any = 1'b0;
      for (int h = 0; h < NH; h++) begin
        if (busy_h[h] && done_cnt[h] != seen_cnt[h]) begin
          seen_cnt[h] = done_cnt[h];
          h_rd[h]     = 1'b0;
          h_wr[h]     = 1'b0;
          busy_h[h]   = 1'b0;
        end
        if (!busy_h[h] && cyc < NCYC && $urandom_range(0, 2) == 0) begin
          kind      = $urandom_range(1, 3);
          h_rd[h]   = kind[0];
          h_wr[h]   = kind[1];
          h_addr[h] = $urandom;
          h_be[h]   = 4'($urandom);
          h_wd[h]   = $urandom;
          busy_h[h] = 1'b1;
        end
        any |= busy_h[h];
      end
      d_wait  = ($urandom_range(0, 3) == 0);
      d_rdata = $urandom;
      if (cyc >= NCYC && !any) break;
    end
    chk("drain_idle", {busy_h[2], busy_h[1], busy_h[0]}, 3'b000);
    step();
    step();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

endmodule
